// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared predictor defaults, BTB entry and saturating counter helper
package branch_predictor_pkg;
  localparam int BP_BTB_ENTRIES = 64;
  localparam int BP_LHT_ENTRIES = 64;
  localparam int BP_LHIST_W = 6;
  localparam int BP_GHIST_W = 8;
  typedef logic [1:0] ctr2_t;
  localparam ctr2_t CTR_INIT = 2'b01;
  typedef struct packed {
    logic        valid;
    logic        is_jump;
    logic [29:0] tag;
    logic [31:0] target;
  } btb_entry_s;
  function automatic ctr2_t sat_ctr_upd(input ctr2_t ctr, input logic taken);
    return taken ? ((ctr == 2'b11) ? ctr : ctr + 2'b01)
                 : ((ctr == 2'b00) ? ctr : ctr - 2'b01);
  endfunction
endpackage

// File: rtl/branch_predictor_btb.sv
// bp_btb: direct-mapped branch target buffer, async clear, combinational read, sync write
module bp_btb
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = BP_BTB_ENTRIES
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] rd_pc,
  output logic        hit,
  output logic        is_jump,
  output logic [31:0] target,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target,
  input  logic        wr_is_jump
);
  localparam int IDX_W = $clog2(ENTRIES);
  btb_entry_s mem [ENTRIES];
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [29:0] rd_tag, wr_tag;
  assign rd_idx = rd_pc[2 +: IDX_W];
  assign wr_idx = wr_pc[2 +: IDX_W];
  // tags keep every PC bit above the index, zero-extended into the fixed-width field
  assign rd_tag = 30'(rd_pc >> (IDX_W + 2));
  assign wr_tag = 30'(wr_pc >> (IDX_W + 2));
  assign hit     = mem[rd_idx].valid && (mem[rd_idx].tag == rd_tag);
  assign is_jump = mem[rd_idx].is_jump;
  assign target  = mem[rd_idx].target;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    else if (wr_en)
      mem[wr_idx] <= '{valid: 1'b1, is_jump: wr_is_jump, tag: wr_tag, target: wr_target};
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: tournament predictor (BTB, local, gshare, chooser) for the IF stage
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BTB_ENTRIES = BP_BTB_ENTRIES,
  parameter int LHT_ENTRIES = BP_LHT_ENTRIES,
  parameter int LHIST_W     = BP_LHIST_W,
  parameter int GHIST_W     = BP_GHIST_W
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] if_pc_i,
  output logic [31:0] pred_pc_o,
  output logic        pred_taken_o,
  output logic        pred_hit_o,
  output logic        glb_taken_o,
  output logic        loc_taken_o,
  input  logic        upd_vld_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_is_br_i,
  input  logic        upd_is_jp_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_glb_taken_i,
  input  logic        upd_loc_taken_i
);
  localparam int LIDX_W = $clog2(LHT_ENTRIES);
  localparam int LPHT_N = 1 << LHIST_W;
  localparam int GPHT_N = 1 << GHIST_W;
  logic [LHIST_W-1:0] lht [LHT_ENTRIES];
  ctr2_t lpht [LPHT_N];
  ctr2_t gpht [GPHT_N];
  ctr2_t chooser [GPHT_N];
  logic [GHIST_W-1:0] ghr;
  logic btb_hit, btb_is_jump, use_glb, up_any, up_br;
  logic [31:0] btb_target;
  logic [LHIST_W-1:0] rd_hist, up_hist;
  logic [GHIST_W-1:0] rd_gidx, up_gidx;
  logic [LIDX_W-1:0] up_lidx;
  assign rd_hist      = lht[if_pc_i[2 +: LIDX_W]];
  assign rd_gidx      = if_pc_i[2 +: GHIST_W] ^ ghr;
  assign loc_taken_o  = lpht[rd_hist][1];
  assign glb_taken_o  = gpht[rd_gidx][1];
  assign use_glb      = chooser[rd_gidx][1];
  assign pred_hit_o   = btb_hit;
  assign pred_taken_o = btb_hit & (btb_is_jump | (use_glb ? glb_taken_o : loc_taken_o));
  assign pred_pc_o    = pred_taken_o ? btb_target : if_pc_i + 32'd4;
  // a combined branch+jump update is a jump, so only pure branches train direction state
  assign up_any  = upd_vld_i & (upd_is_br_i | upd_is_jp_i);
  assign up_br   = upd_vld_i & upd_is_br_i & ~upd_is_jp_i;
  assign up_lidx = upd_pc_i[2 +: LIDX_W];
  assign up_hist = lht[up_lidx];
  assign up_gidx = upd_pc_i[2 +: GHIST_W] ^ ghr;
  bp_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rd_pc      (if_pc_i),
    .hit        (btb_hit),
    .is_jump    (btb_is_jump),
    .target     (btb_target),
    .wr_en      (up_any & upd_taken_i),
    .wr_pc      (upd_pc_i),
    .wr_target  (upd_target_i),
    .wr_is_jump (upd_is_jp_i)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ghr <= '0;
      for (int i = 0; i < LHT_ENTRIES; i++) lht[i] <= '0;
      for (int i = 0; i < LPHT_N; i++) lpht[i] <= CTR_INIT;
      for (int i = 0; i < GPHT_N; i++) gpht[i] <= CTR_INIT;
      for (int i = 0; i < GPHT_N; i++) chooser[i] <= CTR_INIT;
    end else if (up_br) begin
      ghr           <= {ghr[GHIST_W-2:0], upd_taken_i};
      lht[up_lidx]  <= {up_hist[LHIST_W-2:0], upd_taken_i};
      lpht[up_hist] <= sat_ctr_upd(lpht[up_hist], upd_taken_i);
      gpht[up_gidx] <= sat_ctr_upd(gpht[up_gidx], upd_taken_i);
      if (upd_glb_taken_i != upd_loc_taken_i)
        chooser[up_gidx] <= sat_ctr_upd(chooser[up_gidx], upd_glb_taken_i == upd_taken_i);
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench checking the predictor against a table-level model
module tb_branch_predictor;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic [31:0] if_pc_i, pred_pc_o, upd_pc_i, upd_target_i;
  logic pred_taken_o, pred_hit_o, glb_taken_o, loc_taken_o;
  logic upd_vld_i, upd_is_br_i, upd_is_jp_i, upd_taken_i, upd_glb_taken_i, upd_loc_taken_i;
  always #5 clk = ~clk;
  branch_predictor dut (
    .clk_i(clk), .rst_ni(rst_ni), .if_pc_i(if_pc_i), .pred_pc_o(pred_pc_o),
    .pred_taken_o(pred_taken_o), .pred_hit_o(pred_hit_o), .glb_taken_o(glb_taken_o),
    .loc_taken_o(loc_taken_o), .upd_vld_i(upd_vld_i), .upd_pc_i(upd_pc_i),
    .upd_is_br_i(upd_is_br_i), .upd_is_jp_i(upd_is_jp_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_glb_taken_i(upd_glb_taken_i),
    .upd_loc_taken_i(upd_loc_taken_i)
  );
  typedef struct packed {
    logic [31:0] pc;
    logic taken, hit, glb, loc;
  } exp_t;
  exp_t exp_q[$];
  string name_q[$];
  logic chk_stb = 1'b0;
  int checks = 0, passed = 0;
  bit m_val[64], m_jmp[64];
  logic [31:0] m_tag[64], m_tgt[64];
  int unsigned m_lht[64], m_lpht[64], m_gpht[256], m_ch[256], m_ghr;
  function automatic void model_reset();
    m_ghr = 0;
    for (int i = 0; i < 64; i++) begin
      m_val[i] = 0; m_jmp[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_lht[i] = 0; m_lpht[i] = 1;
    end
    for (int i = 0; i < 256; i++) begin
      m_gpht[i] = 1; m_ch[i] = 1;
    end
  endfunction
  function automatic exp_t model_pred(input logic [31:0] pc);
    int unsigned b, g;
    bit dir;
    exp_t e;
    b = (pc >> 2) % 64;
    g = ((pc >> 2) ^ m_ghr) % 256;
    e.hit = m_val[b] && (m_tag[b] == (pc >> 8));
    e.glb = m_gpht[g] >= 2;
    e.loc = m_lpht[m_lht[b]] >= 2;
    dir = (m_ch[g] >= 2) ? e.glb : e.loc;
    e.taken = e.hit && (m_jmp[b] || dir);
    e.pc = e.taken ? m_tgt[b] : pc + 32'd4;
    return e;
  endfunction
  function automatic int unsigned bump(input int unsigned c, input bit up);
    return up ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
  endfunction
  function automatic void model_upd(input logic [31:0] pc, input bit br, jp, tk,
                                    input logic [31:0] tgt, input bit gf, lf);
    int unsigned b, g, h;
    if (!br && !jp) return;
    b = (pc >> 2) % 64;
    if (tk) begin
      m_val[b] = 1; m_jmp[b] = jp; m_tag[b] = pc >> 8; m_tgt[b] = tgt;
    end
    if (jp) return;
    h = m_lht[b];
    g = ((pc >> 2) ^ m_ghr) % 256;
    m_lpht[h] = bump(m_lpht[h], tk);
    m_gpht[g] = bump(m_gpht[g], tk);
    if (gf != lf) m_ch[g] = bump(m_ch[g], gf == tk);
    m_ghr = (m_ghr * 2 + tk) % 256;
    m_lht[b] = (h * 2 + tk) % 64;
  endfunction
  always @(negedge clk) if (chk_stb) begin
    exp_t a, e;
    string n;
    a = {pred_pc_o, pred_taken_o, pred_hit_o, glb_taken_o, loc_taken_o};
    checks++;
    if (exp_q.size() == 0)
      $display("FAIL no_expect: DUT output pc=%h with no expected entry queued", a.pc);
    else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (a === e) passed++;
      else $display("FAIL %s: got pc=%h tk=%b hit=%b glb=%b loc=%b, want pc=%h tk=%b hit=%b glb=%b loc=%b",
                    n, a.pc, a.taken, a.hit, a.glb, a.loc, e.pc, e.taken, e.hit, e.glb, e.loc);
    end
  end
  task automatic step(input logic [31:0] pc, input bit chk, input string nm,
                      input bit v, input logic [31:0] upc, input bit br, jp, tk,
                      input logic [31:0] tgt, input bit gf, lf);
    if_pc_i = pc; upd_vld_i = v; upd_pc_i = upc; upd_is_br_i = br; upd_is_jp_i = jp;
    upd_taken_i = tk; upd_target_i = tgt; upd_glb_taken_i = gf; upd_loc_taken_i = lf;
    if (chk) begin
      exp_q.push_back(model_pred(pc));
      name_q.push_back(nm);
    end
    chk_stb = chk;
    @(posedge clk);
    if (v) model_upd(upc, br, jp, tk, tgt, gf, lf);
    #1;
  endtask
  task automatic look(input logic [31:0] pc, input string nm);
    step(pc, 1, nm, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
  endtask
  task automatic train(input logic [31:0] upc, input bit br, jp, tk, input logic [31:0] tgt);
    exp_t e;
    e = model_pred(upc);
    step(32'h0, 0, "", 1, upc, br, jp, tk, tgt, e.glb, e.loc);
  endtask
  task automatic rst_pulse(input logic [31:0] pc, input string nm);
    if_pc_i = pc; upd_vld_i = 1; upd_pc_i = pc; upd_is_br_i = 1; upd_is_jp_i = 0;
    upd_taken_i = 1; upd_target_i = 32'h40;
    rst_ni = 1'b0;
    model_reset();
    exp_q.push_back(model_pred(pc));
    name_q.push_back(nm);
    chk_stb = 1;
    #5;
    rst_ni = 1'b1; upd_vld_i = 0; chk_stb = 0;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] pick();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return 32'($urandom_range(0, 3)) * 256 + 32'($urandom_range(0, 7)) * 4;
  endfunction
  initial begin
    if_pc_i = '0; upd_vld_i = 0; upd_pc_i = '0; upd_is_br_i = 0; upd_is_jp_i = 0;
    upd_taken_i = 0; upd_target_i = '0; upd_glb_taken_i = 0; upd_loc_taken_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    look(32'h100, "reset_pred");
    train(32'h200, 0, 1, 1, 32'h400);
    look(32'h200, "jal_hit");
    train(32'h100, 1, 0, 1, 32'h80);
    look(32'h100, "br_after_1");
    repeat (5) train(32'h100, 1, 0, 1, 32'h80);
    look(32'h100, "br_after_6");
    train(32'h100, 1, 0, 1, 32'h80);
    look(32'h100, "br_after_7");
    train(32'h100, 1, 0, 1, 32'h80);
    look(32'h100, "br_after_8");
    train(32'h100, 1, 0, 1, 32'h80);
    look(32'h100, "br_after_9");
    rst_pulse(32'h100, "async_reset");
    look(32'h100, "post_reset");
    repeat (3) train(32'h100, 1, 0, 1, 32'h80);
    look(32'h200, "alias_miss");
    look(32'h100, "alias_hit");
    look(32'hFFFF_FFFC, "pc_wrap");
    step(32'h100, 1, "same_cycle_old", 1, 32'h100, 1, 0, 0, 32'h0, 0, 1);
    look(32'h100, "same_cycle_new");
    step(32'h0, 0, "", 1, 32'h300, 0, 0, 1, 32'h700, 1, 0);
    look(32'h300, "noop_update");
    train(32'h300, 1, 1, 1, 32'h500);
    look(32'h300, "br_jp_as_jump");
    look(32'h100, "br_jp_no_hist");
    for (int i = 0; i < 400; i++) begin
      logic [31:0] p, up, t;
      bit br, jp, tk, gf, lf;
      exp_t e;
      p = pick();
      up = pick();
      jp = $urandom_range(0, 4) == 0;
      br = $urandom_range(0, 5) != 0;
      tk = jp ? 1'b1 : 1'($urandom_range(0, 1));
      t = $urandom & 32'hFFFF_FFFC;
      e = model_pred(up);
      gf = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : e.glb;
      lf = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : e.loc;
      step(p, 1, "rand", $urandom_range(0, 3) != 0, up, br, jp, tk, t, gf, lf);
    end
    chk_stb = 0;
    @(posedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL queue_drain: %0d expected entries left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
